// File: rtl/cpu_fetch_unit.sv
// Instruction fetch unit: tracks outstanding instruction-memory reads, buffers
// returned words in a prefetch queue for decode, and squashes wrong-path fetches on redirect.
module cpu_fetch_unit #(
    parameter int unsigned    PC_W     = 16,
    parameter int unsigned    INSTR_W  = 16,
    parameter int unsigned    PC_INC   = 2,
    parameter int unsigned    DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_ex_jump_r,
    input  logic [PC_W-1:0]    i_ex_target,
    input  logic               i_dc_jump_i,
    input  logic [PC_W-1:0]    i_dc_target,
    output logic               o_mem_rd,
    output logic [PC_W-1:0]    o_mem_addr,
    input  logic               i_mem_ready,
    input  logic               i_mem_rdata_valid,
    input  logic [INSTR_W-1:0] i_mem_rdata,
    output logic               o_dc_valid,
    output logic [INSTR_W-1:0] o_dc_instr,
    output logic [PC_W-1:0]    o_dc_pc,
    input  logic               i_dc_stall,
    output logic               o_redirect
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    entry_t             q_mem_q [DEPTH];
    logic [PC_W-1:0]    fetch_pc_q,    fetch_pc_d;
    logic [PC_W-1:0]    rsp_pc_q,      rsp_pc_d;
    logic [PTR_W-1:0]   head_q,        head_d;
    logic [PTR_W-1:0]   tail_q,        tail_d;
    logic [CNT_W-1:0]   count_q,       count_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   discard_q,     discard_d;

    logic               redirect;
    logic [PC_W-1:0]    tgt;
    logic [OCC_W-1:0]   occ;
    logic               cap;
    logic               accept;
    logic               rsp_dec;
    logic               drop;
    logic               push;
    logic               dc_valid;
    logic               pop;
    logic [CNT_W-1:0]   out_after_rsp;

    // Redirect selection and issue/queue handshakes
    always_comb begin
        redirect = i_ex_jump_r | i_dc_jump_i;
        tgt      = i_ex_jump_r ? i_ex_target : i_dc_target;
        // A redirect flushes the queue this cycle, so its entries no longer count against issue.
        occ      = (redirect ? OCC_W'(0) : OCC_W'(count_q)) + OCC_W'(outstanding_q);
        cap      = occ < OCC_W'(DEPTH);
        accept   = cap & i_mem_ready;
        rsp_dec  = i_mem_rdata_valid & (outstanding_q != '0);
        drop     = discard_q != '0;
        push     = i_mem_rdata_valid & ~drop & ~redirect;
        dc_valid = (count_q != '0) & ~redirect;
        pop      = dc_valid & ~i_dc_stall;
        out_after_rsp = outstanding_q - CNT_W'(rsp_dec);
    end

    // Externally visible outputs, forced quiet while reset is held
    always_comb begin
        o_mem_rd   = i_reset_n & cap;
        o_redirect = i_reset_n & redirect;
        o_dc_valid = i_reset_n & dc_valid;
        o_mem_addr = !i_reset_n ? RESET_PC : (redirect ? tgt : fetch_pc_q);
        o_dc_instr = q_mem_q[head_q].instr;
        o_dc_pc    = q_mem_q[head_q].pc;
    end

    // Next-state logic
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        outstanding_d = out_after_rsp + CNT_W'(accept);
        discard_d     = discard_q;

        if (redirect) begin
            fetch_pc_d = accept ? tgt + PC_W'(PC_INC) : tgt;
        end else if (accept) begin
            fetch_pc_d = fetch_pc_q + PC_W'(PC_INC);
        end

        if (redirect) begin
            // Every read still in flight before this cycle's issue belongs to the wrong path.
            discard_d = out_after_rsp;
            rsp_pc_d  = tgt;
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
        end else begin
            if (i_mem_rdata_valid && drop) begin
                discard_d = discard_q - CNT_W'(1);
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + PC_W'(PC_INC);
                tail_d   = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State registers
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // Queue storage; contents are only meaningful while count_q covers them
    always_ff @(posedge i_clk) begin
        if (i_reset_n && push) begin
            q_mem_q[tail_q] <= '{pc: rsp_pc_q, instr: i_mem_rdata};
        end
    end

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Randomized bench for cpu_fetch_unit: an in-order memory model plus a queue-level
// reference of what decode should see, checked every cycle.
module tb_cpu_fetch_unit;

    localparam int unsigned DEPTH = 4;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_ex_jump_r = 1'b0;
    logic [15:0] i_ex_target = '0;
    logic        i_dc_jump_i = 1'b0;
    logic [15:0] i_dc_target = '0;
    logic        o_mem_rd;
    logic [15:0] o_mem_addr;
    logic        i_mem_ready = 1'b0;
    logic        i_mem_rdata_valid = 1'b0;
    logic [15:0] i_mem_rdata = '0;
    logic        o_dc_valid;
    logic [15:0] o_dc_instr;
    logic [15:0] o_dc_pc;
    logic        i_dc_stall = 1'b0;
    logic        o_redirect;

    cpu_fetch_unit #(
        .PC_W(16), .INSTR_W(16), .PC_INC(2), .DEPTH(DEPTH), .RESET_PC(16'h0000)
    ) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_ex_jump_r(i_ex_jump_r), .i_ex_target(i_ex_target),
        .i_dc_jump_i(i_dc_jump_i), .i_dc_target(i_dc_target),
        .o_mem_rd(o_mem_rd), .o_mem_addr(o_mem_addr),
        .i_mem_ready(i_mem_ready), .i_mem_rdata_valid(i_mem_rdata_valid),
        .i_mem_rdata(i_mem_rdata),
        .o_dc_valid(o_dc_valid), .o_dc_instr(o_dc_instr), .o_dc_pc(o_dc_pc),
        .i_dc_stall(i_dc_stall), .o_redirect(o_redirect)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [15:0] addr;
        int          cyc;
        bit          stale;
    } req_t;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
    } ent_t;

    req_t        pending[$];
    ent_t        fifo[$];
    logic [15:0] fpc = '0;
    logic [15:0] exp_stream = '0;
    int          cyc_now = 0;
    int          total = 0;
    int          bad = 0;
    int          p_ready = 0, p_rvalid = 0, p_stall = 0, p_jump = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc_now, obs, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic cycle(input bit rst, input bit fex, input logic [15:0] tex,
                         input bit fdc, input logic [15:0] tdc);
        bit          ex, dc, redir, acc, e_rd, e_val;
        logic [15:0] tgt, e_addr;
        req_t        r;
        @(negedge i_clk);
        ex = fex || ($urandom_range(99) < p_jump);
        dc = fdc || ($urandom_range(99) < p_jump);
        i_reset_n   = !rst;
        i_ex_jump_r = ex;
        i_ex_target = fex ? tex : (16'($urandom) & 16'hFFFE);
        i_dc_jump_i = dc;
        i_dc_target = fdc ? tdc : (16'($urandom) & 16'hFFFE);
        i_mem_ready = ($urandom_range(99) < p_ready);
        i_dc_stall  = ($urandom_range(99) < p_stall);
        if (!rst && pending.size() > 0 && pending[0].cyc < cyc_now &&
            $urandom_range(99) < p_rvalid) begin
            i_mem_rdata_valid = 1'b1;
            i_mem_rdata       = mem_word(pending[0].addr);
        end else begin
            i_mem_rdata_valid = 1'b0;
            i_mem_rdata       = 16'($urandom);
        end
        #1;
        redir  = ex || dc;
        tgt    = ex ? i_ex_target : i_dc_target;
        e_rd   = ((redir ? 0 : fifo.size()) + pending.size()) < DEPTH;
        e_addr = redir ? tgt : fpc;
        e_val  = (fifo.size() > 0) && !redir;
        if (rst) begin
            check_eq("rst_mem_rd", o_mem_rd, 0);
            check_eq("rst_dc_valid", o_dc_valid, 0);
            check_eq("rst_redirect", o_redirect, 0);
            check_eq("rst_mem_addr", o_mem_addr, 16'h0000);
        end else begin
            check_eq("mem_rd", o_mem_rd, e_rd);
            check_eq("mem_addr", o_mem_addr, e_addr);
            check_eq("redirect", o_redirect, redir);
            check_eq("dc_valid", o_dc_valid, e_val);
            if (e_val) begin
                check_eq("dc_pc", o_dc_pc, fifo[0].pc);
                check_eq("dc_instr", o_dc_instr, fifo[0].instr);
                if (!i_dc_stall) check_eq("stream_pc", o_dc_pc, exp_stream);
            end
        end
        @(posedge i_clk);
        if (rst) begin
            fifo.delete();
            pending.delete();
            fpc        = 16'h0000;
            exp_stream = 16'h0000;
        end else begin
            acc = e_rd && i_mem_ready;
            if (e_val && !i_dc_stall) begin
                void'(fifo.pop_front());
                exp_stream = exp_stream + 16'd2;
            end
            if (i_mem_rdata_valid) begin
                r = pending.pop_front();
                if (!r.stale && !redir) fifo.push_back('{pc: r.addr, instr: mem_word(r.addr)});
            end
            if (redir) begin
                fifo.delete();
                for (int k = 0; k < pending.size(); k++) pending[k].stale = 1'b1;
                exp_stream = tgt;
            end
            if (acc) pending.push_back('{addr: e_addr, cyc: cyc_now, stale: 1'b0});
            fpc = redir ? (acc ? tgt + 16'd2 : tgt) : (acc ? fpc + 16'd2 : fpc);
        end
        cyc_now++;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    endtask

    initial begin
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);

        // streaming with a single-cycle memory and no stalls
        p_ready = 100; p_rvalid = 100; p_stall = 0; p_jump = 0;
        idle(20);

        // decode back-pressure fills the queue, then drains
        p_stall = 100; idle(10);
        p_stall = 0;   idle(10);

        // build up in-flight reads, then redirect from decode
        p_rvalid = 0; idle(3);
        cycle(1'b0, 1'b0, 16'h0, 1'b1, 16'h0100);
        p_rvalid = 100; idle(10);

        // execute redirect beats decode redirect
        cycle(1'b0, 1'b1, 16'h0200, 1'b1, 16'h0100);
        idle(10);

        // memory not ready, redirect during the wait
        p_ready = 0; idle(5);
        cycle(1'b0, 1'b0, 16'h0, 1'b1, 16'h0300);
        idle(2);
        p_ready = 100; idle(10);

        // PC wrap-around, then reset mid-stream
        cycle(1'b0, 1'b0, 16'h0, 1'b1, 16'hFFFC);
        idle(10);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        idle(10);

        // randomized traffic
        p_ready = 70; p_rvalid = 60; p_stall = 30; p_jump = 4;
        idle(3000);
        p_ready = 90; p_rvalid = 40; p_stall = 60; p_jump = 1;
        idle(1500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
